// File: rtl/ps2_receptor_trama.sv
// PS/2 device-to-host frame receiver: synchronises and deglitches the bus, deserialises
// 11-bit frames and publishes each verified byte with a one-cycle strobe.
module ps2_receptor_trama #(
  parameter int unsigned FILTER_LEN     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 10000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] dato,
  output logic       cod_verificado,
  output logic       inicio_datos,
  output logic       error_trama,
  output logic       recibiendo
);

  localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TimeoutMax = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StRecv, StCheck} state_e;

  logic                  clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
  logic [FILTER_LEN-1:0] filt_q;
  logic                  clk_f_q, clk_f_d;
  logic                  fall_tick;

  state_e                state_q;
  logic [3:0]            bit_cnt_q;
  logic [TW-1:0]         to_cnt_q;
  logic [9:0]            shreg_q;
  logic [7:0]            dato_q;
  logic                  cod_q, ini_q, err_q, rec_q;
  logic                  frame_ok;

  // Filtered level only changes once the whole window agrees.
  always_comb begin
    clk_f_d = clk_f_q;
    if (&filt_q) begin
      clk_f_d = 1'b1;
    end else if (~|filt_q) begin
      clk_f_d = 1'b0;
    end
  end

  assign fall_tick = clk_f_q & ~clk_f_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_s1_q <= 1'b1;
      clk_s2_q <= 1'b1;
      dat_s1_q <= 1'b1;
      dat_s2_q <= 1'b1;
      filt_q   <= '1;
      clk_f_q  <= 1'b1;
    end else begin
      clk_s1_q <= ps2_clk;
      clk_s2_q <= clk_s1_q;
      dat_s1_q <= ps2_data;
      dat_s2_q <= dat_s1_q;
      filt_q   <= {filt_q[FILTER_LEN-2:0], clk_s2_q};
      clk_f_q  <= clk_f_d;
    end
  end

  // shreg_q[7:0] data, [8] parity, [9] stop once all ten bits are in.
  assign frame_ok = (^shreg_q[8:0]) & shreg_q[9];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      bit_cnt_q <= '0;
      to_cnt_q  <= '0;
      shreg_q   <= '0;
      dato_q    <= 8'h00;
      cod_q     <= 1'b0;
      ini_q     <= 1'b0;
      err_q     <= 1'b0;
      rec_q     <= 1'b0;
    end else begin
      cod_q <= 1'b0;
      ini_q <= 1'b0;
      err_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (fall_tick && !dat_s2_q) begin
            state_q   <= StRecv;
            bit_cnt_q <= '0;
            to_cnt_q  <= '0;
            ini_q     <= 1'b1;
            rec_q     <= 1'b1;
          end
        end
        StRecv: begin
          if (fall_tick) begin
            shreg_q   <= {dat_s2_q, shreg_q[9:1]};
            bit_cnt_q <= bit_cnt_q + 4'd1;
            to_cnt_q  <= '0;
            if (bit_cnt_q == 4'd9) begin
              state_q <= StCheck;
            end
          end else if (to_cnt_q >= TimeoutMax) begin
            state_q <= StIdle;
            err_q   <= 1'b1;
            rec_q   <= 1'b0;
          end else begin
            to_cnt_q <= to_cnt_q + TW'(1);
          end
        end
        StCheck: begin
          state_q <= StIdle;
          rec_q   <= 1'b0;
          if (frame_ok) begin
            dato_q <= shreg_q[7:0];
            cod_q  <= 1'b1;
          end else begin
            err_q <= 1'b1;
          end
        end
        default: begin
          state_q <= StIdle;
          rec_q   <= 1'b0;
        end
      endcase
    end
  end

  assign dato           = dato_q;
  assign cod_verificado = cod_q;
  assign inicio_datos   = ini_q;
  assign error_trama    = err_q;
  assign recibiendo     = rec_q;

endmodule

// File: tb/tb_ps2_receptor_trama.sv
// Directed bench for ps2_receptor_trama: frame table plus glitch, timeout and reset sequences.
module tb_ps2_receptor_trama;

  localparam int unsigned FL   = 8;
  localparam int unsigned TO   = 200;
  localparam int unsigned HALF = 40;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [7:0] dato;
  logic       cod_verificado, inicio_datos, error_trama, recibiendo;

  int checks = 0;
  int failures = 0;

  int n_cod = 0, n_err = 0, n_ini = 0;
  int bad_align = 0, wide = 0, both = 0;
  logic rec_prev = 1'b0, cod_prev = 1'b0, err_prev = 1'b0, ini_prev = 1'b0;

  ps2_receptor_trama #(
    .FILTER_LEN    (FL),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .ps2_clk       (ps2_clk),
    .ps2_data      (ps2_data),
    .dato          (dato),
    .cod_verificado(cod_verificado),
    .inicio_datos  (inicio_datos),
    .error_trama   (error_trama),
    .recibiendo    (recibiendo)
  );

  always #5 clk = ~clk;

  // Strobe monitor, sampled on the inactive edge.
  always @(negedge clk) begin
    if (cod_verificado) begin
      n_cod <= n_cod + 1;
      // cod must appear in the cycle right after CHECK, i.e. as recibiendo drops
      if (!(rec_prev && !recibiendo)) bad_align <= bad_align + 1;
    end
    if (error_trama) n_err <= n_err + 1;
    if (inicio_datos) n_ini <= n_ini + 1;
    if (cod_verificado && error_trama) both <= both + 1;
    if ((cod_verificado && cod_prev) || (error_trama && err_prev) ||
        (inicio_datos && ini_prev)) wide <= wide + 1;
    rec_prev <= recibiendo;
    cod_prev <= cod_verificado;
    err_prev <= error_trama;
    ini_prev <= inicio_datos;
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    ps2_data = b;
    cycles(HALF);
    ps2_clk = 1'b0;
    cycles(HALF);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par, input logic stp);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(par);
    send_bit(stp);
    ps2_data = 1'b1;
  endtask

  task automatic glitch();
    ps2_clk = 1'b0;
    cycles(3);
    ps2_clk = 1'b1;
  endtask

  typedef struct {
    string      name;
    logic [7:0] data;
    logic       par;
    logic       stp;
    logic [7:0] exp_dato;
    int         exp_good;
  } vec_t;

  vec_t vecs[4];
  int c0, e0, i0;

  initial begin
    vecs[0] = '{"f1C",      8'h1C, 1'b0, 1'b1, 8'h1C, 1};
    vecs[1] = '{"fF0_par1", 8'hF0, 1'b1, 1'b1, 8'hF0, 1};
    vecs[2] = '{"fF0_par0", 8'hF0, 1'b0, 1'b1, 8'hF0, 0};
    vecs[3] = '{"f1C_stp0", 8'h1C, 1'b0, 1'b0, 8'hF0, 0};

    cycles(4);
    check("rst_dato", dato, 8'h00);
    check("rst_cod", cod_verificado, 0);
    check("rst_ini", inicio_datos, 0);
    check("rst_err", error_trama, 0);
    check("rst_rec", recibiendo, 0);
    rst = 1'b0;
    cycles(30);

    foreach (vecs[k]) begin
      c0 = n_cod; e0 = n_err; i0 = n_ini;
      send_frame(vecs[k].data, vecs[k].par, vecs[k].stp);
      cycles(FL + 20);
      check({vecs[k].name, "_ini"}, n_ini - i0, 1);
      check({vecs[k].name, "_cod"}, n_cod - c0, vecs[k].exp_good);
      check({vecs[k].name, "_err"}, n_err - e0, 1 - vecs[k].exp_good);
      check({vecs[k].name, "_dato"}, dato, vecs[k].exp_dato);
      check({vecs[k].name, "_rec"}, recibiendo, 0);
    end

    // Glitch in idle must not start a frame.
    i0 = n_ini;
    glitch();
    cycles(40);
    check("glitch_idle_ini", n_ini - i0, 0);
    check("glitch_idle_rec", recibiendo, 0);

    // Glitches mid-frame must not shift extra bits; 0x5A has four ones, parity 1.
    c0 = n_cod; e0 = n_err; i0 = n_ini;
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    cycles(10);
    glitch();
    cycles(10);
    send_bit(1'b0);
    send_bit(1'b1);
    glitch();
    cycles(5);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    ps2_data = 1'b1;
    cycles(FL + 20);
    check("glitch_frame_ini", n_ini - i0, 1);
    check("glitch_frame_cod", n_cod - c0, 1);
    check("glitch_frame_err", n_err - e0, 0);
    check("glitch_frame_dato", dato, 8'h5A);

    // Timeout after start + 4 data bits.
    c0 = n_cod; e0 = n_err;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    ps2_data = 1'b1;
    check("to_rec_mid", recibiendo, 1);
    cycles(TO + 60);
    check("to_err", n_err - e0, 1);
    check("to_cod", n_cod - c0, 0);
    check("to_rec", recibiendo, 0);
    check("to_dato", dato, 8'h5A);
    c0 = n_cod;
    send_frame(8'h1C, 1'b0, 1'b1);
    cycles(FL + 20);
    check("after_to_cod", n_cod - c0, 1);
    check("after_to_dato", dato, 8'h1C);

    // Reset after 6 bits of a frame.
    c0 = n_cod; e0 = n_err;
    send_bit(1'b0);
    for (int i = 0; i < 5; i++) send_bit(1'b1);
    rst = 1'b1;
    cycles(3);
    check("mrst_dato", dato, 8'h00);
    check("mrst_rec", recibiendo, 0);
    check("mrst_cod", cod_verificado, 0);
    check("mrst_err", error_trama, 0);
    rst = 1'b0;
    cycles(TO + 60);
    check("mrst_no_strobe", (n_cod - c0) + (n_err - e0), 0);
    c0 = n_cod; i0 = n_ini;
    send_frame(8'h29, 1'b0, 1'b1);
    cycles(FL + 20);
    check("after_rst_ini", n_ini - i0, 1);
    check("after_rst_cod", n_cod - c0, 1);
    check("after_rst_dato", dato, 8'h29);

    check("cod_alignment", bad_align, 0);
    check("strobe_width", wide, 0);
    check("cod_err_exclusive", both, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
